// File: rtl/uart_pkg.sv
// ============================================================================
// Package     : uart_pkg
// Description : Shared state encoding, parity constants and configuration
//               record for the UART transmit controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_STOP2_EN
    , STOP2 = 3'd5
`endif
  } tx_state_e;

  // Per-frame configuration captured when a frame is accepted.
  typedef struct packed {
    logic par_en;
    logic par_typ;
  } tx_cfg_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_parity_calc.sv
// ============================================================================
// Module      : uart_parity_calc
// Description : Combinational parity bit for one payload word (even/odd).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_TYP,
  output logic                  par_bit
);

  assign par_bit = (^P_DATA) ^ (PAR_TYP == PAR_ODD);

endmodule : uart_parity_calc

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit framing FSM (start/data/parity/stop) driving an
//               external serializer. Macro UART_TX_STOP2_EN adds a 2nd stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Ser_Data,
  input  logic                  Ser_Done,
  output logic                  Ser_Enable,
  output logic                  BUSY,
  output logic                  TX_OUT
);

  tx_state_e state_q, state_d;
  logic      par_q, par_d;
  tx_cfg_t   cfg_q, cfg_d;
  logic      w_par_typ_sel;
  logic      w_par_bit;

  // Outside IDLE the calculator sees the frame's own parity type.
  assign w_par_typ_sel = (state_q == IDLE) ? PAR_TYP : cfg_q.par_typ;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .P_DATA  (P_DATA),
    .PAR_TYP (w_par_typ_sel),
    .par_bit (w_par_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      par_q   <= 1'b0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      cfg_q   <= cfg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    cfg_d   = cfg_q;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d       = START;
          par_d         = w_par_bit;
          cfg_d.par_en  = PAR_EN;
          cfg_d.par_typ = PAR_TYP;
        end
      end
      START:  state_d = DATA;
      DATA: begin
        if (Ser_Done) begin
          state_d = cfg_q.par_en ? PARITY : STOP;
        end
      end
      PARITY: state_d = STOP;
`ifdef UART_TX_STOP2_EN
      STOP:   state_d = STOP2;
      STOP2:  state_d = IDLE;
`else
      STOP:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TX_OUT     = 1'b1;
    BUSY       = 1'b0;
    Ser_Enable = 1'b0;
    case (state_q)
      START: begin
        TX_OUT = 1'b0;
        BUSY   = 1'b1;
      end
      DATA: begin
        TX_OUT     = Ser_Data;
        BUSY       = 1'b1;
        Ser_Enable = 1'b1;
      end
      PARITY: begin
        TX_OUT = par_q;
        BUSY   = 1'b1;
      end
`ifdef UART_TX_STOP2_EN
      STOP, STOP2: begin
`else
      STOP: begin
`endif
        TX_OUT = 1'b1;
        BUSY   = 1'b1;
      end
      default: begin
        TX_OUT     = 1'b1;
        BUSY       = 1'b0;
        Ser_Enable = 1'b0;
      end
    endcase
  end

endmodule : uart_tx_ctrl

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl with a serializer model
//               and a frame-level reference model. Honours UART_TX_STOP2_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          Ser_Data, Ser_Done, Ser_Enable, BUSY, TX_OUT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Ser_Data   (Ser_Data),
    .Ser_Done   (Ser_Done),
    .Ser_Enable (Ser_Enable),
    .BUSY       (BUSY),
    .TX_OUT     (TX_OUT)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Serializer: loads while the controller is idle, shifts LSB first.
  logic [DW-1:0] ser_sh;
  int            ser_cnt;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_sh  <= '0;
      ser_cnt <= 0;
    end else if (!BUSY) begin
      ser_sh  <= P_DATA;
      ser_cnt <= 0;
    end else if (Ser_Enable) begin
      ser_sh  <= ser_sh >> 1;
      ser_cnt <= ser_cnt + 1;
    end
  end
  assign Ser_Data = ser_sh[0];
  assign Ser_Done = Ser_Enable && (ser_cnt == DW - 1);

  // Reference: a whole frame of expected {tx,busy,en} cycles is queued on accept.
  typedef struct packed {
    logic tx;
    logic busy;
    logic en;
  } exp_t;

  localparam exp_t IDLE_E = '{tx: 1'b1, busy: 1'b0, en: 1'b0};
  exp_t q[$];
  exp_t cur = IDLE_E;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q.delete();
      cur <= IDLE_E;
    end else begin
      if (!cur.busy && Data_Valid) begin
        q.push_back('{tx: 1'b0, busy: 1'b1, en: 1'b0});
        for (int i = 0; i < DW; i++) q.push_back('{tx: P_DATA[i], busy: 1'b1, en: 1'b1});
        if (PAR_EN)
          q.push_back('{tx: 1'(($countones(P_DATA) + int'(PAR_TYP)) % 2), busy: 1'b1, en: 1'b0});
        for (int s = 0; s < N_STOP; s++) q.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b0});
      end
      if (q.size() > 0) cur <= q.pop_front();
      else              cur <= IDLE_E;
    end
  end

  always @(negedge CLK) begin
    cmp("model_tx", int'(TX_OUT), int'(cur.tx));
    cmp("model_busy", int'(BUSY), int'(cur.busy));
    cmp("model_en", int'(Ser_Enable), int'(cur.en));
  end

  task automatic run_frame(input logic [DW-1:0] d, input logic en, input logic typ,
                           output logic [0:15] seq, output int nbusy);
    @(negedge CLK); #1;
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; Data_Valid = 1'b1;
    @(negedge CLK); #1;
    Data_Valid = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 16; i++) begin
      seq[i] = TX_OUT;
      if (BUSY) nbusy++;
      @(negedge CLK); #1;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY && k < 30) begin
      @(negedge CLK); #1;
      k++;
    end
    cmp("idle_timeout", int'(BUSY), 0);
  endtask

  // Holds Data_Valid high and measures start-to-start spacing of three frames.
  task automatic measure(input logic [DW-1:0] d, input logic en, input int exp_period,
                         input string nm);
    int st[3];
    int n = 0;
    logic pb, pt;
    @(negedge CLK); #1;
    P_DATA = d; PAR_EN = en; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    pb = BUSY; pt = TX_OUT;
    for (int c = 0; c < 48; c++) begin
      @(negedge CLK); #1;
      if (BUSY && !pb && n < 3) begin
        st[n] = c;
        n++;
        cmp({nm, "_gap_tx"}, int'(pt), 1);
        cmp({nm, "_gap_busy"}, int'(pb), 0);
        cmp({nm, "_start_tx"}, int'(TX_OUT), 0);
      end
      pb = BUSY; pt = TX_OUT;
    end
    Data_Valid = 1'b0;
    cmp({nm, "_frames"}, n, 3);
    if (n == 3) begin
      cmp({nm, "_period1"}, st[1] - st[0], exp_period);
      cmp({nm, "_period2"}, st[2] - st[1], exp_period);
    end
    wait_idle();
  endtask

  initial begin
    logic [0:15] seq;
    int          nb;
    logic [10:0] a5_exp = 11'b01010010101;
    logic [10:0] s5a_exp = 11'b00101101011;
    logic [DW-1:0] got;

    #1 RST = 1'b0;
    #1;
    cmp("rst_tx", int'(TX_OUT), 1);
    cmp("rst_busy", int'(BUSY), 0);
    cmp("rst_en", int'(Ser_Enable), 0);
    repeat (3) @(negedge CLK);
    #1 RST = 1'b1;

    // A5, even parity
    run_frame(8'hA5, 1'b1, 1'b0, seq, nb);
    for (int i = 0; i < 11; i++) cmp("a5_bit", int'(seq[i]), int'(a5_exp[10 - i]));
    cmp("a5_busy_cycles", nb, 10 + N_STOP);

    // Odd parity corner words
    run_frame(8'h01, 1'b1, 1'b1, seq, nb);
    cmp("odd_01_parity", int'(seq[9]), 0);
    run_frame(8'h00, 1'b1, 1'b1, seq, nb);
    cmp("odd_00_parity", int'(seq[9]), 1);

    // Back-to-back frames, no parity and with parity
`ifdef UART_TX_STOP2_EN
    measure(8'hFF, 1'b0, 12, "held_nopar");
    measure(8'h5A, 1'b1, 13, "held_par");
`else
    measure(8'hFF, 1'b0, 11, "held_nopar");
    measure(8'h5A, 1'b1, 12, "held_par");
`endif

    // Data_Valid pulse mid-frame is ignored
    @(negedge CLK); #1;
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK); #1;
    Data_Valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      seq[i] = TX_OUT;
      if (BUSY) nb++;
      if (i == 4) begin
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b1; Data_Valid = 1'b1;
      end
      if (i == 5) Data_Valid = 1'b0;
      @(negedge CLK); #1;
    end
    for (int i = 0; i < DW; i++) got[i] = seq[i + 1];
    cmp("ignore_dv_data", int'(got), 8'h96);
    cmp("ignore_dv_parity", int'(seq[9]), 0);
    cmp("ignore_dv_busy_cycles", nb, 10 + N_STOP);

    // Reset during data bit 4, then a clean frame
    @(negedge CLK); #1;
    P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK); #1;
    Data_Valid = 1'b0;
    repeat (5) begin
      @(negedge CLK); #1;
    end
    cmp("pre_rst_busy", int'(BUSY), 1);
    #1 RST = 1'b0;
    #1;
    cmp("midrst_tx", int'(TX_OUT), 1);
    cmp("midrst_busy", int'(BUSY), 0);
    cmp("midrst_en", int'(Ser_Enable), 0);
    @(negedge CLK); #1 RST = 1'b1;
    @(negedge CLK); #1;
    cmp("post_rst_idle", int'(BUSY), 0);
    run_frame(8'h5A, 1'b1, 1'b1, seq, nb);
    for (int i = 0; i < 11; i++) cmp("post_rst_bit", int'(seq[i]), int'(s5a_exp[10 - i]));
    cmp("post_rst_busy_cycles", nb, 10 + N_STOP);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule : tb_uart_tx_ctrl

`default_nettype wire

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, frame payload width in bits.
REQ-002 SHALL have port: CLK  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: RST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: P_DATA  in  DATA_WIDTH  parallel word, also loaded by the serializer.
REQ-005 SHALL have port: Data_Valid  in  1  request to transmit P_DATA.
REQ-006 SHALL have port: PAR_EN  in  1  parity bit enable.
REQ-007 SHALL have port: PAR_TYP  in  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port: Ser_Data  in  1  current serializer output bit.
REQ-009 SHALL have port: Ser_Done  in  1  serializer last-bit flag.
REQ-010 SHALL have port: Ser_Enable  out  1  serializer shift/count enable.
REQ-011 SHALL have port: BUSY  out  1  frame in progress; blocks serializer load.
REQ-012 SHALL have port: TX_OUT  out  1  serial line, idle high.

Function
REQ-013 SHALL implement Moore FSM states IDLE, START, DATA, PARITY, STOP (plus STOP2, see Configuration).
REQ-014 SHALL decode outputs from the state register only, except TX_OUT in DATA, which is Ser_Data.
REQ-015 SHALL drive, per state: IDLE: TX_OUT=1, BUSY=0, Ser_Enable=0; START: TX_OUT=0, BUSY=1, Ser_Enable=0.
REQ-016 SHALL drive, per state: DATA: TX_OUT=Ser_Data, BUSY=1, Ser_Enable=1; PARITY: TX_OUT=par_reg, BUSY=1; STOP/STOP2: TX_OUT=1, BUSY=1.
REQ-017 SHALL, in IDLE with Data_Valid=1: go to START, latch par_reg from P_DATA, latch PAR_EN and PAR_TYP.
REQ-018 SHALL compute par_reg as XOR-reduce of P_DATA for even parity, and its inverse for odd.
REQ-019 SHALL go START->DATA unconditionally after one cycle.
REQ-020 SHALL stay in DATA until Ser_Done=1, giving exactly DATA_WIDTH cycles; bit 0 goes first.
REQ-021 SHALL, on Ser_Done=1 in DATA, go to PARITY if latched PAR_EN=1, else to STOP.
REQ-022 SHALL go PARITY->STOP after one cycle, and STOP->IDLE after one cycle.
REQ-023 SHALL ignore Data_Valid in every non-IDLE state; no queuing.
REQ-024 SHALL spend at least one IDLE cycle between frames; with Data_Valid held high the period is DATA_WIDTH+4 cycles with parity and DATA_WIDTH+3 without.
REQ-025 SHALL not let changes to PAR_EN or PAR_TYP mid-frame affect the current frame.
REQ-026 SHALL treat Ser_Done outside DATA as don't-care.

Reset
REQ-027 SHALL, on RST=0, immediately force state=IDLE, par_reg=0 and the latched configuration to 0, regardless of clock.
REQ-028 SHALL, during reset, hold TX_OUT=1, BUSY=0 and Ser_Enable=0; a frame cut by reset is abandoned and never resumed.
REQ-029 SHALL treat the first rising CLK after RST deasserts as an IDLE cycle that may accept Data_Valid.

Configuration
REQ-030 SHALL, with macro UART_TX_STOP2_EN defined, add state STOP2: STOP->STOP2->IDLE, giving two stop bits and period +1.
REQ-031 SHALL, without UART_TX_STOP2_EN, contain no STOP2 logic; STOP->IDLE directly.

Structure
REQ-032 SHALL take the state encoding type and the PAR_EVEN=0 / PAR_ODD=1 constants from shared package uart_pkg.
REQ-033 SHALL place the parity computation in sub-module uart_parity_calc (P_DATA, PAR_TYP in; parity bit out, combinational).

Verification
REQ-034 SHALL check: reset then Data_Valid pulse with P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1; BUSY high 11 cycles.
REQ-035 SHALL check: P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; with P_DATA=8'h00 and odd parity -> parity bit 1.
REQ-036 SHALL check: PAR_EN=0, P_DATA=8'hFF, Data_Valid held high -> frame start bits exactly 11 cycles apart, with one IDLE cycle (TX_OUT=1, BUSY=0) between frames.
REQ-037 SHALL check: Data_Valid pulsed in DATA with P_DATA=8'h3C -> current frame unaffected; no second frame.
REQ-038 SHALL check: RST asserted during bit 4 of DATA -> TX_OUT=1 and BUSY=0 with no clock edge; a new frame after release is correct.
REQ-039 SHALL check: with UART_TX_STOP2_EN defined, PAR_EN=1 -> two stop cycles; frame period 13 cycles with Data_Valid held high.
